muxa_sched: RTL
===============

# muxa_sched

Two-port weighted round-robin scheduler that shares the `muxA` datapath between a 32-bit requester (port 1) and a 16-bit requester (port 2) in the DDR3 controller. It accepts one request per cycle via valid/ready handshake, drives `muxA`'s `sel`, `in1` and `in2` from registers, and tracks `muxA`'s one-cycle register latency. It presents `out_valid`/`out_src` aligned with `muxA.outA`.

## Interface
- `W1`, default 2: max consecutive port-1 grants while port 2 is waiting (≥1).
- `W2`, default 1: max consecutive port-2 grants while port 1 is waiting (≥1).
- `FIRST_PORT`, default 1: winner of the first contended arbitration after reset (1 or 2).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `p1_valid` in 1: port-1 request.
- `p1_data` in 32: port-1 payload.
- `p1_ready` out 1: port-1 grant this cycle.
- `p2_valid` in 1: port-2 request.
- `p2_data` in 16: port-2 payload.
- `p2_ready` out 1: port-2 grant this cycle.
- `mux_sel` out 1: to `muxA.sel`. 1 selects `in1`; 0 selects `{16'h0, in2}`.
- `mux_in1` out 32: to `muxA.in1`.
- `mux_in2` out 16: to `muxA.in2`.
- `out_valid` out 1: `muxA.outA` holds a newly scheduled word this cycle.
- `out_src` out 1: source of that word (1 = port 1, 0 = port 2).
- `gnt_cnt1`, `gnt_cnt2` out 16 each: per-port grant counters.

## Operation
- State register: IDLE (after reset only), OWN1, OWN2 (last port granted). Consecutive-grant counter `consec` (width clog2(max(W1,W2))+1), saturating at its max value.
- Arbitration is combinational from registered state and both valids:
  - Neither valid: no grant.
  - Exactly one valid: that port wins.
  - Both valid, IDLE: `FIRST_PORT` wins.
  - Both valid, OWNx: port x wins if `consec < Wx`; otherwise the other port wins.
- `pN_ready` = pN wins. Ready never depends on `pN_data`. Both readys are 0 while `rst` is high.
- On a grant to port 1: `mux_sel<=1`, `mux_in1<=p1_data`, `mux_in2` holds.
- On a grant to port 2: `mux_sel<=0`, `mux_in2<=p2_data`, `mux_in1` holds.
- On any grant: state<=OWNwinner. `consec<=consec+1` if the winner equals the owner, else `consec<=1`. `gnt_cntN` increments and wraps 0xFFFF→0.
- No grant: mux outputs, state and `consec` all hold, so `outA` stays stable. State never returns to IDLE except via reset.
- Tag pipe: stage-0 `{v0,src0}` loads `{grant, winner==1}` every edge. `out_valid<=v0` and `out_src<=src0` on the next edge.
- No downstream backpressure; consumers sample `outA` when `out_valid` is high.

## Timing
- Handshake completes at edge N when `pN_valid & pN_ready`.
- After edge N: `mux_*` reflect the request.
- After edge N+1: `muxA.outA` holds the word and `out_valid=1`, `out_src` set. Latency is 2 edges; throughput is 1 request per cycle.
- Back-to-back grants produce back-to-back `out_valid` pulses in grant order.
- Reset (edge with `rst=1`):
  - `mux_sel=0`, `mux_in1=0`, `mux_in2=0`.
  - `v0=0`, `out_valid=0`, `out_src=0`.
  - state=IDLE, `consec=0`, `gnt_cnt1=gnt_cnt2=0`.
- Reset mid-operation: in-flight tags are discarded, so no `out_valid` is produced for a request accepted in the edge before reset.
- Valids that arrive in the same cycle reset deasserts are not granted until the cycle after.
- Contention pattern with W1=2, W2=1, both continuously valid from IDLE and FIRST_PORT=1: 1,1,2,1,1,2,…

## Structure
- Shared package `ddr3_ctrl_pkg`:
  - state enum `muxa_state_t` {IDLE, OWN1, OWN2}.
  - constants `SRC_P1=1'b1`, `SRC_P2=1'b0`, `MUXA_W1_DEF`, `MUXA_W2_DEF`.
- Sub-module `muxa_wrr_arb`: pure arbitration plus state/`consec` registers. Outputs `gnt1`/`gnt2`.
- `muxa_sched` holds mux registers, tag pipe and counters.
- `muxA` itself is instantiated by the parent, not inside this block.

## Test plan
- Port-1 only: `p1_data=32'hA5A5A5A5`, one-cycle valid.
  - `p1_ready=1` immediately.
  - `mux_sel=1` after edge N.
  - After edge N+1: `outA=A5A5A5A5`, `out_valid=1`, `out_src=1`, `gnt_cnt1=1`.
- Port-2 only: `p2_data=16'h5678`.
  - After edge N+1: `outA=32'h00005678`, `out_src=0`.
  - `mux_in1` unchanged from its previous value.
- Both valid continuously for 9 cycles (W1=2, W2=1), with port-1 data C7C7C7C7 and port-2 data ABCD.
  - Grant order 1,1,2,1,1,2,1,1,2.
  - `out_src` sequence matches, 2 edges delayed.
  - `gnt_cnt1=6`, `gnt_cnt2=3`.
- Idle hold: one grant of B6B6B6B6, then no valids for 5 cycles.
  - `out_valid` pulses exactly once.
  - `mux_*` and `outA` stay B6B6B6B6.
  - State stays OWN1.
- Reset mid-op: accept A5A5A5A5 at edge N, assert `rst` at edge N+1.
  - `out_valid` stays 0.
  - All outputs return to their reset values.
  - The next contended arbitration goes to `FIRST_PORT`.
- Counter wrap: 65536 port-2 grants → `gnt_cnt2` returns to 0 and `gnt_cnt1` stays 0.

Source files
------------

// File: rtl/ddr3_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_ctrl_pkg
// Shared types and constants for the DDR3 controller datapath schedulers.
//   muxa_state_t : muxA scheduler ownership state (IDLE only after reset)
//   SRC_P1/SRC_P2: out_src encodings for port 1 / port 2
//   MUXA_W*_DEF  : default weighted round-robin weights
// ---------------------------------------------------------------------------
package ddr3_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } muxa_state_t;

    localparam logic SRC_P1 = 1'b1;
    localparam logic SRC_P2 = 1'b0;

    localparam int unsigned MUXA_W1_DEF = 2;
    localparam int unsigned MUXA_W2_DEF = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/muxa_wrr_arb.sv
// ---------------------------------------------------------------------------
// muxa_wrr_arb
// Two-port weighted round-robin arbiter for the muxA scheduler. Holds the
// ownership state and the consecutive-grant counter; grants are purely
// combinational from that state and the two valids.
//   clk, rst          : clock, synchronous active-high reset
//   p1_valid/p2_valid : requests
//   gnt1/gnt2         : one-hot (or zero) grant, forced low during reset
// ---------------------------------------------------------------------------
module muxa_wrr_arb
    import ddr3_ctrl_pkg::*;
#(
    parameter int unsigned W1         = MUXA_W1_DEF,
    parameter int unsigned W2         = MUXA_W2_DEF,
    parameter int unsigned FIRST_PORT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic p1_valid,
    input  logic p2_valid,
    output logic gnt1,
    output logic gnt2
);

    localparam int unsigned CW = $clog2(max_u(W1, W2)) + 1;
    localparam logic [CW-1:0] W1_C = CW'(W1);
    localparam logic [CW-1:0] W2_C = CW'(W2);

    muxa_state_t   state_q, state_d;
    logic [CW-1:0] consec_q, consec_d;
    logic          win1, win2;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
        end
    end

    // Next state: run length grows while the same port keeps winning,
    // saturating so long uncontended bursts cannot wrap back below Wx.
    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        if (gnt1 || gnt2) begin
            state_d = gnt1 ? OWN1 : OWN2;
            if (state_d == state_q)
                consec_d = (consec_q == '1) ? consec_q : consec_q + 1'b1;
            else
                consec_d = CW'(1);
        end
    end

    // Outputs: grant decision
    always_comb begin
        win1 = 1'b0;
        win2 = 1'b0;
        if (p1_valid && !p2_valid) begin
            win1 = 1'b1;
        end else if (!p1_valid && p2_valid) begin
            win2 = 1'b1;
        end else if (p1_valid && p2_valid) begin
            case (state_q)
                OWN1: begin
                    win1 = (consec_q <  W1_C);
                    win2 = (consec_q >= W1_C);
                end
                OWN2: begin
                    win2 = (consec_q <  W2_C);
                    win1 = (consec_q >= W2_C);
                end
                default: begin
                    win1 = (FIRST_PORT == 1);
                    win2 = (FIRST_PORT != 1);
                end
            endcase
        end
        gnt1 = win1 & ~rst;
        gnt2 = win2 & ~rst;
    end

endmodule

// File: rtl/muxa_sched.sv
// ---------------------------------------------------------------------------
// muxa_sched
// Shares the external muxA datapath between a 32-bit requester (port 1) and
// a 16-bit requester (port 2). Drives muxA's sel/in1/in2 from registers and
// carries a two-stage tag pipe so out_valid/out_src line up with muxA.outA.
//   clk, rst            : clock, synchronous active-high reset
//   p1_valid/data/ready : port-1 handshake, 32-bit payload
//   p2_valid/data/ready : port-2 handshake, 16-bit payload
//   mux_sel/in1/in2     : to muxA (sel=1 picks in1, sel=0 picks {16'h0,in2})
//   out_valid/out_src   : outA holds a new word / its source (1=p1, 0=p2)
//   gnt_cnt1/gnt_cnt2   : wrapping per-port grant counters
// ---------------------------------------------------------------------------
module muxa_sched
    import ddr3_ctrl_pkg::*;
#(
    parameter int unsigned W1         = MUXA_W1_DEF,
    parameter int unsigned W2         = MUXA_W2_DEF,
    parameter int unsigned FIRST_PORT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p1_valid,
    input  logic [31:0] p1_data,
    output logic        p1_ready,
    input  logic        p2_valid,
    input  logic [15:0] p2_data,
    output logic        p2_ready,
    output logic        mux_sel,
    output logic [31:0] mux_in1,
    output logic [15:0] mux_in2,
    output logic        out_valid,
    output logic        out_src,
    output logic [15:0] gnt_cnt1,
    output logic [15:0] gnt_cnt2
);

    logic        gnt1, gnt2;
    logic        sel_q, sel_d;
    logic [31:0] in1_q, in1_d;
    logic [15:0] in2_q, in2_d;
    logic        v0_q, v0_d;
    logic        src0_q, src0_d;
    logic        ov_q, osrc_q;
    logic [15:0] cnt1_q, cnt1_d;
    logic [15:0] cnt2_q, cnt2_d;

    muxa_wrr_arb #(
        .W1         (W1),
        .W2         (W2),
        .FIRST_PORT (FIRST_PORT)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .p1_valid (p1_valid),
        .p2_valid (p2_valid),
        .gnt1     (gnt1),
        .gnt2     (gnt2)
    );

    // Without a grant every mux register holds, keeping outA stable.
    always_comb begin
        sel_d  = sel_q;
        in1_d  = in1_q;
        in2_d  = in2_q;
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (gnt1) begin
            sel_d  = 1'b1;
            in1_d  = p1_data;
            cnt1_d = cnt1_q + 16'd1;
        end else if (gnt2) begin
            sel_d  = 1'b0;
            in2_d  = p2_data;
            cnt2_d = cnt2_q + 16'd1;
        end
        v0_d   = gnt1 | gnt2;
        src0_d = gnt1 ? SRC_P1 : SRC_P2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= 1'b0;
            in1_q  <= '0;
            in2_q  <= '0;
            v0_q   <= 1'b0;
            src0_q <= 1'b0;
            ov_q   <= 1'b0;
            osrc_q <= 1'b0;
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            sel_q  <= sel_d;
            in1_q  <= in1_d;
            in2_q  <= in2_d;
            v0_q   <= v0_d;
            src0_q <= src0_d;
            ov_q   <= v0_q;
            osrc_q <= src0_q;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign p1_ready  = gnt1;
    assign p2_ready  = gnt2;
    assign mux_sel   = sel_q;
    assign mux_in1   = in1_q;
    assign mux_in2   = in2_q;
    assign out_valid = ov_q;
    assign out_src   = osrc_q;
    assign gnt_cnt1  = cnt1_q;
    assign gnt_cnt2  = cnt2_q;

endmodule
